// File: rtl/band_scale_ramp.sv
// Equalizer band gain stage: ramped pot gain applied to NUM_CH lanes with
// saturation, a 3-stage valid pipeline, mute and a sticky clip counter.
module band_scale_lane #(
  parameter int AUDIO_W    = 16,
  parameter int GAIN_W     = 12,
  parameter int FRAC_SHIFT = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en2_i,
  input  logic               en3_i,
  input  logic [GAIN_W-1:0]  gain_i,
  input  logic [AUDIO_W-1:0] audio_i,
  output logic [AUDIO_W-1:0] out_o,
  output logic               sat_o
);
  localparam int PW = AUDIO_W + GAIN_W + 1;

  logic signed [PW-1:0]   g_ext, a_ext, prod_q, shifted;
  logic [PW-AUDIO_W:0]    upper;
  logic                   ovf;

  assign g_ext   = {{(AUDIO_W+1){1'b0}}, gain_i};
  assign a_ext   = {{(GAIN_W+1){audio_i[AUDIO_W-1]}}, audio_i};
  assign shifted = prod_q >>> FRAC_SHIFT;
  // In range only when every bit from the sign down to bit AUDIO_W-1 agrees
  assign upper   = shifted[PW-1:AUDIO_W-1];
  assign ovf     = !((&upper) || !(|upper));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      out_o  <= '0;
      sat_o  <= 1'b0;
    end else begin
      if (en2_i) prod_q <= g_ext * a_ext;
      if (en3_i) begin
        sat_o <= ovf;
        if (ovf) out_o <= shifted[PW-1] ? {1'b1, {(AUDIO_W-1){1'b0}}}
                                        : {1'b0, {(AUDIO_W-1){1'b1}}};
        else     out_o <= shifted[AUDIO_W-1:0];
      end
    end
  end
endmodule

module band_scale_ramp #(
  parameter int NUM_CH     = 2,
  parameter int AUDIO_W    = 16,
  parameter int POT_W      = 24,
  parameter int GAIN_W     = 12,
  parameter int FRAC_SHIFT = 10,
  parameter int RAMP_STEP  = 16,
  parameter int CLIP_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [POT_W-1:0]          pot,
  input  logic                      pot_vld,
  input  logic                      mute,
  input  logic                      vld_in,
  input  logic [NUM_CH*AUDIO_W-1:0] audio_in,
  output logic                      vld_out,
  output logic [NUM_CH*AUDIO_W-1:0] audio_out,
  output logic [NUM_CH-1:0]         sat_out,
  output logic                      ramping,
  output logic [GAIN_W-1:0]         gain_cur,
  input  logic                      clr_clip,
  output logic [CLIP_W-1:0]         clip_cnt
);
  localparam int STAGES = 3;
  localparam logic [1:0] S_HOLD = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2;
  localparam logic [GAIN_W-1:0] STEP     = GAIN_W'(RAMP_STEP);
  localparam logic [CLIP_W-1:0] CLIP_MAX = '1;

  logic [GAIN_W-1:0] target_q, gain_q, gain_d, eff_target, diff;
  logic [1:0]        state;

  assign eff_target = mute ? '0 : target_q;

  always_comb begin
    state = S_HOLD;
    if (gain_q < eff_target)      state = S_UP;
    else if (gain_q > eff_target) state = S_DOWN;
  end

  // Clamp the last step onto the target so the ramp never overshoots or wraps
  always_comb begin
    gain_d = gain_q;
    diff   = '0;
    case (state)
      S_UP: begin
        diff   = eff_target - gain_q;
        gain_d = (diff <= STEP) ? eff_target : gain_q + STEP;
      end
      S_DOWN: begin
        diff   = gain_q - eff_target;
        gain_d = (diff <= STEP) ? eff_target : gain_q - STEP;
      end
      default: gain_d = gain_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      gain_q   <= '0;
    end else begin
      if (pot_vld) target_q <= pot[POT_W-1 -: GAIN_W];
      if (vld_in)  gain_q   <= gain_d;
    end
  end

  assign ramping  = (state != S_HOLD);
  assign gain_cur = gain_q;

  logic [STAGES:0]                     vld_pipe;
  logic [STAGES-1:0]                   vld_q;
  logic [NUM_CH-1:0][AUDIO_W-1:0]      audio_q, out_arr;
  logic [GAIN_W-1:0]                   gain_s1_q;

  assign vld_pipe = {vld_q, vld_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      audio_q   <= '0;
      gain_s1_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (vld_in) begin
        audio_q   <= audio_in;
        gain_s1_q <= gain_q;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    band_scale_lane #(
      .AUDIO_W(AUDIO_W), .GAIN_W(GAIN_W), .FRAC_SHIFT(FRAC_SHIFT)
    ) u_lane (
      .clk(clk), .rst_n(rst_n),
      .en2_i(vld_pipe[1]), .en3_i(vld_pipe[2]),
      .gain_i(gain_s1_q), .audio_i(audio_q[i]),
      .out_o(out_arr[i]), .sat_o(sat_out[i])
    );
  end

  assign vld_out   = vld_pipe[STAGES];
  assign audio_out = out_arr;

  logic [CLIP_W-1:0] clip_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          clip_q <= '0;
    else if (clr_clip)                                   clip_q <= '0;
    else if (vld_out && (|sat_out) && clip_q != CLIP_MAX) clip_q <= clip_q + 1'b1;
  end
  assign clip_cnt = clip_q;
endmodule

// File: tb/tb_band_scale_ramp.sv
// Directed bench for band_scale_ramp: ramp, latency, saturation, clip, mute, reset.
module tb_band_scale_ramp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pot;
  logic        pot_vld, mute, vld_in, clr_clip;
  logic [31:0] audio_in, audio_out;
  logic        vld_out, ramping;
  logic [1:0]  sat_out;
  logic [11:0] gain_cur;
  logic [7:0]  clip_cnt;
  int          errors = 0;
  int          checks = 0;

  band_scale_ramp dut (
    .clk(clk), .rst_n(rst_n), .pot(pot), .pot_vld(pot_vld), .mute(mute),
    .vld_in(vld_in), .audio_in(audio_in), .vld_out(vld_out),
    .audio_out(audio_out), .sat_out(sat_out), .ramping(ramping),
    .gain_cur(gain_cur), .clr_clip(clr_clip), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample, then watch it emerge exactly three cycles later and hold.
  task automatic send_chk(input logic [31:0] a, input bit chk_out,
                          input logic [31:0] exp_out, input logic [1:0] exp_sat,
                          input logic [11:0] exp_gain);
    vld_in = 1'b1; audio_in = a;
    step();
    vld_in = 1'b0;
    chk("gain_after_sample", gain_cur, exp_gain);
    chk("vld_lat1", vld_out, 1'b0);
    step();
    chk("vld_lat2", vld_out, 1'b0);
    step();
    chk("vld_lat3", vld_out, 1'b1);
    if (chk_out) begin
      chk("audio_out", audio_out, exp_out);
      chk("sat_out", sat_out, exp_sat);
    end
    step();
    chk("vld_drop", vld_out, 1'b0);
    if (chk_out) chk("audio_hold", audio_out, exp_out);
  endtask

  task automatic burst(input int n, input logic [31:0] a);
    vld_in = 1'b1; audio_in = a;
    repeat (n) step();
    vld_in = 1'b0;
  endtask

  task automatic load_pot(input logic [23:0] p);
    pot = p; pot_vld = 1'b1;
    step();
    pot_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pot = '0; pot_vld = 1'b0; mute = 1'b0; vld_in = 1'b0;
    clr_clip = 1'b0; audio_in = '0;
    step(); step();
    chk("rst_gain", gain_cur, 12'h000);
    chk("rst_vld", vld_out, 1'b0);
    chk("rst_audio", audio_out, 32'h0);
    chk("rst_sat", sat_out, 2'b00);
    chk("rst_clip", clip_cnt, 8'h00);
    chk("rst_ramping", ramping, 1'b0);
    rst_n = 1'b1;
    step();

    // Ramp 0 -> 0x400, one sample per 4 cycles
    load_pot(24'h400000);
    chk("ramp_start", ramping, 1'b1);
    for (int k = 0; k < 64; k++) begin
      send_chk({16'hEDCC, 16'h1234}, (k == 0) || (k == 32),
               (k == 32) ? {16'hF6E6, 16'h091A} : 32'h0, 2'b00, 12'(16 * (k + 1)));
      chk("ramp_flag", ramping, (k != 63));
    end
    send_chk({16'hEDCC, 16'h1234}, 1'b1, {16'hEDCC, 16'h1234}, 2'b00, 12'h400);

    // Ramp up to 0xFFF: last step is clamped, not overshot
    load_pot(24'hFFF000);
    burst(191, 32'h0);
    chk("ramp_ff0", gain_cur, 12'hFF0);
    chk("ramp_ff0_flag", ramping, 1'b1);
    burst(1, 32'h0);
    chk("ramp_fff", gain_cur, 12'hFFF);
    chk("ramp_fff_flag", ramping, 1'b0);
    repeat (3) step();
    chk("clip_zero", clip_cnt, 8'h00);

    // Saturation at gain 0xFFF
    send_chk({16'h8000, 16'h7FFF}, 1'b1, {16'h8000, 16'h7FFF}, 2'b11, 12'hFFF);
    chk("clip_one", clip_cnt, 8'h01);
    send_chk({16'hFF00, 16'h0100}, 1'b1, {16'hFC00, 16'h03FF}, 2'b00, 12'hFFF);
    chk("clip_nosat", clip_cnt, 8'h01);

    // Clip counter sticks at max
    burst(253, {16'h7FFF, 16'h7FFF});
    repeat (4) step();
    chk("clip_254", clip_cnt, 8'hFE);
    burst(2, {16'h7FFF, 16'h7FFF});
    repeat (4) step();
    chk("clip_sticky", clip_cnt, 8'hFF);

    // clr_clip wins over an increment on a saturated vld_out
    vld_in = 1'b1; audio_in = {16'h8000, 16'h8000};
    step();
    vld_in = 1'b0;
    step(); step();
    chk("clr_vld", vld_out, 1'b1);
    chk("clr_sat", sat_out, 2'b11);
    clr_clip = 1'b1;
    step();
    clr_clip = 1'b0;
    chk("clr_clip", clip_cnt, 8'h00);

    // Back down to 0x400, then mute ramp
    load_pot(24'h400000);
    burst(192, 32'h0);
    chk("down_400", gain_cur, 12'h400);
    repeat (3) step();
    mute = 1'b1;
    #1;
    chk("mute_ramping", ramping, 1'b1);
    burst(63, {16'hEDCC, 16'h1234});
    chk("mute_010", gain_cur, 12'h010);
    burst(1, {16'hEDCC, 16'h1234});
    chk("mute_zero", gain_cur, 12'h000);
    chk("mute_hold", ramping, 1'b0);
    repeat (3) step();
    send_chk({16'hEDCC, 16'h1234}, 1'b1, 32'h0, 2'b00, 12'h000);
    mute = 1'b0;
    #1;
    chk("unmute_ramping", ramping, 1'b1);
    burst(64, 32'h0);
    chk("unmute_400", gain_cur, 12'h400);
    chk("unmute_hold", ramping, 1'b0);

    // Reset mid-ramp with samples in flight
    mute = 1'b1;
    burst(32, {16'hEDCC, 16'h1234});
    chk("pre_rst_gain", gain_cur, 12'h200);
    chk("pre_rst_vld", vld_out, 1'b1);
    mute = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gain", gain_cur, 12'h000);
    chk("mid_rst_vld", vld_out, 1'b0);
    chk("mid_rst_audio", audio_out, 32'h0);
    chk("mid_rst_ramping", ramping, 1'b0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_vld", vld_out, 1'b0);
    end
    chk("post_rst_gain", gain_cur, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/band_scale_ramp.md
Name: band_scale_ramp

Overview:
Multi-channel equalizer band gain stage. It multiplies NUM_CH parallel FIR band outputs by a slide-pot gain, then saturates the result to AUDIO_W bits. Gain changes ramp toward the new target by a fixed step on each sample, which suppresses zipper noise. The block sits between the per-band FIR filters and the band summer, with a fixed-latency valid pipeline, mute, and a sticky clip counter for the UI.

Parameters:
NUM_CH, 2, number of parallel audio lanes (L/R); all lanes share one gain
AUDIO_W, 16, signed audio sample width in and out
POT_W, 24, width of the A2D pot reading
GAIN_W, 12, unsigned gain width; taken from the top GAIN_W bits of POT
FRAC_SHIFT, 10, right-shift applied to the product; gain 2^FRAC_SHIFT = unity
RAMP_STEP, 16, gain increment or decrement per accepted sample
CLIP_W, 8, clip counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pot  in  POT_W  A2D reading from the slide pot
pot_vld  in  1  one-cycle strobe; load a new gain target from pot
mute  in  1  level; while high, the effective target is 0
vld_in  in  1  one-cycle strobe; audio_in holds a new sample set
audio_in  in  NUM_CH*AUDIO_W  packed signed samples; lane i is at bits [i*AUDIO_W +: AUDIO_W]
vld_out  out  1  one-cycle strobe; audio_out is valid
audio_out  out  NUM_CH*AUDIO_W  packed scaled, saturated samples
sat_out  out  NUM_CH  per-lane saturation flag, aligned with vld_out
ramping  out  1  high while the current gain differs from the effective target
gain_cur  out  GAIN_W  current applied gain
clr_clip  in  1  synchronous clear of clip_cnt
clip_cnt  out  CLIP_W  count of output samples with any lane saturated; sticks at max

Behaviour:
- Reset (async, rst_n=0): all of the following are 0: gain_cur, target, pipeline valids, vld_out, audio_out, sat_out, clip_cnt, ramping. The state machine enters HOLD.
- Target register:
  - On pot_vld, target <= pot[POT_W-1 -: GAIN_W].
  - eff_target = mute ? 0 : target.
  - mute does not alter the target register; deasserting mute ramps the gain back to the stored target.
- Ramp FSM with states HOLD, UP, DOWN, evaluated every cycle:
  - HOLD if gain_cur==eff_target; UP if gain_cur<eff_target; DOWN otherwise.
  - ramping = (state != HOLD).
  - gain_cur updates only in cycles with vld_in=1.
  - UP: gain_cur <= (eff_target-gain_cur <= RAMP_STEP) ? eff_target : gain_cur+RAMP_STEP.
  - DOWN: mirror of UP; it never overshoots or wraps.
  - The sample accepted in a cycle uses the gain_cur value from before that cycle's update.
- Simultaneous pot_vld and vld_in: the sample uses the old gain_cur and ramps toward the old eff_target. The new target takes effect next cycle.
- Pipeline, three register stages, fixed latency:
  - Stage 1 captures audio_in, gain_cur and vld_in.
  - Stage 2 registers the products.
  - Stage 3 registers the saturated output.
  - vld_out is high exactly 3 cycles after vld_in is high. Back-to-back vld_in every cycle is supported.
  - There is no backpressure.
- Arithmetic, per lane:
  - prod = signed({1'b0,gain}) * signed(audio), width AUDIO_W+GAIN_W+1.
  - shifted = prod >>> FRAC_SHIFT (arithmetic shift; truncate toward −inf).
  - If shifted > 2^(AUDIO_W-1)-1, the output is the max positive value (0x7FFF) and sat=1.
  - If shifted < −2^(AUDIO_W-1), the output is 0x8000 and sat=1.
  - Otherwise the output is shifted[AUDIO_W-1:0] and sat=0.
- audio_out and sat_out hold their last values while vld_out=0.
- clip_cnt:
  - Increments by 1 on a vld_out cycle with |sat_out.
  - Saturates at 2^CLIP_W-1.
  - clr_clip has priority over an increment in the same cycle (result 0).
- Reset mid-ramp or mid-pipeline: in-flight samples are discarded and no vld_out is produced for them. Gain restarts from 0.

Test Plan:
- Unity gain: pot=24'h400000, pot_vld, then 64 vld_in with audio=0x1234/0xEDCC → gain_cur reaches 0x400 after 64 samples. The next sample produces out=0x1234/0xEDCC, sat=0, vld_out 3 cycles after vld_in.
- Ramp/latency: from gain 0, target 0x400, one vld_in per 4 cycles → gain_cur steps 0,16,32,…,0x400 in 64 samples. ramping drops the cycle gain_cur==0x400. Each vld_out lags its vld_in by exactly 3 cycles.
- Saturation: gain settled at 0xFFF, audio=0x7FFF/0x8000 → out 0x7FFF/0x8000, sat_out=2'b11, clip_cnt +1 per sample. With audio=0x0100 → out 0x03FF, sat=0.
- Clip counter: 300 saturated samples → clip_cnt sticks at 255. clr_clip coincident with a saturated vld_out → 0.
- Mute: gain 0x400, assert mute → gain_cur falls by 16 per sample to 0 and out=0. Release mute → gain ramps back to 0x400 with no pot_vld.
- Reset mid-ramp: assert rst_n=0 while gain_cur=0x200 and two samples are in flight → all outputs 0 immediately, no vld_out after release, gain_cur=0.
